// File: rtl/conv_gemm.sv
// Weight-stationary GEMM over im2col data: out(m,n) = sum_k W(m,k)*X(k,n), one memory read port
// and one write port, each result costing 3K+1 cycles.
//   state   | meaning
//   IDLE    | waiting for start
//   FETCH_W | weight address on addr_rd
//   FETCH_X | weight captured, im2col address on addr_rd
//   ACC     | multiply-accumulate one term
//   WRITE   | emit one result
//   DONE    | all results written, sticky until reset
module conv_gemm #(
  parameter int          IMG_C       = 1,
  parameter int          IMG_W       = 8,
  parameter int          IMG_H       = 8,
  parameter int          FILTER_SIZE = 3,
  parameter int          FILTER_NUM  = 2,
  parameter int          DATA_WIDTH  = 8,
  parameter int          OUT_WIDTH   = 32,
  parameter int          ADDR_WIDTH  = 32,
  parameter logic [15:0] IM2COL_BASE = 16'h2000,
  parameter logic [15:0] WEIGHT_BASE = 16'h4000,
  parameter logic [15:0] OUTPUT_BASE = 16'h6000,
  parameter int          RELU        = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] data_rd,
  output logic [ADDR_WIDTH-1:0] addr_rd,
  output logic [ADDR_WIDTH-1:0] addr_wr,
  output logic [OUT_WIDTH-1:0]  data_wr,
  output logic                  mem_wr_en,
  output logic                  done
);

  localparam int K  = IMG_C * FILTER_SIZE * FILTER_SIZE;
  localparam int N  = IMG_W * IMG_H;
  localparam int M  = FILTER_NUM;
  localparam int KW = (K > 1) ? $clog2(K) : 1;
  localparam int NW = (N > 1) ? $clog2(N) : 1;
  localparam int MW = (M > 1) ? $clog2(M) : 1;

  localparam logic [KW-1:0] K_LAST = KW'(K - 1);
  localparam logic [NW-1:0] N_LAST = NW'(N - 1);
  localparam logic [MW-1:0] M_LAST = MW'(M - 1);

  localparam logic [ADDR_WIDTH-1:0] K_A  = ADDR_WIDTH'(K);
  localparam logic [ADDR_WIDTH-1:0] N_A  = ADDR_WIDTH'(N);
  localparam logic [ADDR_WIDTH-1:0] IM_B = ADDR_WIDTH'(IM2COL_BASE);
  localparam logic [ADDR_WIDTH-1:0] W_B  = ADDR_WIDTH'(WEIGHT_BASE);
  localparam logic [ADDR_WIDTH-1:0] O_B  = ADDR_WIDTH'(OUTPUT_BASE);

  typedef enum logic [2:0] {
    IDLE, FETCH_W, FETCH_X, ACC, WRITE, DONE
  } state_t;

  state_t                state;
  logic [KW-1:0]         k;
  logic [NW-1:0]         n;
  logic [MW-1:0]         m;
  logic [DATA_WIDTH-1:0] weight;
  logic [OUT_WIDTH-1:0]  acc;
  logic [OUT_WIDTH-1:0]  w_ext;
  logic [OUT_WIDTH-1:0]  x_ext;
  logic [OUT_WIDTH-1:0]  prod;

  function automatic logic [ADDR_WIDTH-1:0] w_addr(input logic [MW-1:0] mi, input logic [KW-1:0] ki);
    return W_B + ADDR_WIDTH'(mi) * K_A + ADDR_WIDTH'(ki);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] x_addr(input logic [KW-1:0] ki, input logic [NW-1:0] ni);
    return IM_B + ADDR_WIDTH'(ki) * N_A + ADDR_WIDTH'(ni);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] o_addr(input logic [MW-1:0] mi, input logic [NW-1:0] ni);
    return O_B + ADDR_WIDTH'(mi) * N_A + ADDR_WIDTH'(ni);
  endfunction

  // Low OUT_WIDTH bits of an unsigned product of sign-extended operands equal the signed product.
  assign w_ext = {{(OUT_WIDTH-DATA_WIDTH){weight[DATA_WIDTH-1]}}, weight};
  assign x_ext = {{(OUT_WIDTH-DATA_WIDTH){data_rd[DATA_WIDTH-1]}}, data_rd};
  assign prod  = w_ext * x_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      k         <= '0;
      n         <= '0;
      m         <= '0;
      weight    <= '0;
      acc       <= '0;
      addr_rd   <= W_B;
      addr_wr   <= O_B;
      data_wr   <= '0;
      mem_wr_en <= 1'b0;
      done      <= 1'b0;
    end else begin
      mem_wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            k       <= '0;
            n       <= '0;
            m       <= '0;
            acc     <= '0;
            addr_rd <= w_addr('0, '0);
            state   <= FETCH_W;
          end
        end
        FETCH_W: begin
          addr_rd <= x_addr(k, n);
          state   <= FETCH_X;
        end
        FETCH_X: begin
          weight <= data_rd;
          state  <= ACC;
        end
        ACC: begin
          acc <= acc + prod;
          if (k == K_LAST) begin
            state <= WRITE;
          end else begin
            k       <= k + 1'b1;
            addr_rd <= w_addr(m, k + 1'b1);
            state   <= FETCH_W;
          end
        end
        WRITE: begin
          mem_wr_en <= 1'b1;
          addr_wr   <= o_addr(m, n);
          data_wr   <= ((RELU != 0) && acc[OUT_WIDTH-1]) ? '0 : acc;
          acc       <= '0;
          k         <= '0;
          if (n == N_LAST) begin
            n <= '0;
            if (m == M_LAST) begin
              state <= DONE;
            end else begin
              m       <= m + 1'b1;
              addr_rd <= w_addr(m + 1'b1, '0);
              state   <= FETCH_W;
            end
          end else begin
            n       <= n + 1'b1;
            addr_rd <= w_addr(m, '0);
            state   <= FETCH_W;
          end
        end
        DONE: begin
          done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_gemm.sv
// Bench for conv_gemm: a RELU=0 and a RELU=1 instance share stimulus and a pattern-driven memory model;
// expected writes are queued when a run starts and popped as the DUTs write.
module tb_conv_gemm;
  localparam int K = 9;
  localparam int N = 64;
  localparam int M = 2;
  localparam int FIRST_WR = 3 * K + 1;
  localparam int DONE_CYC = M * N * (3 * K + 1) + 1;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  data_rd, r_data_rd;
  logic [31:0] addr_rd, addr_wr, r_addr_rd, r_addr_wr;
  logic [31:0] data_wr, r_data_wr;
  logic        mem_wr_en, r_mem_wr_en, done, r_done;

  int n_tests = 0;
  int n_fail  = 0;
  int pat     = 1;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t q[$];
  wr_t rq[$];

  typedef struct {
    int          pat;
    int          drop_at;
    bit          use_model;
    logic [31:0] exp_val;
    logic [31:0] exp_relu;
  } vec_t;
  vec_t vecs[3];

  conv_gemm u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .data_rd(data_rd),
    .addr_rd(addr_rd), .addr_wr(addr_wr), .data_wr(data_wr),
    .mem_wr_en(mem_wr_en), .done(done)
  );

  conv_gemm #(.RELU(1)) u_relu (
    .clk(clk), .rst_n(rst_n), .start(start), .data_rd(r_data_rd),
    .addr_rd(r_addr_rd), .addr_wr(r_addr_wr), .data_wr(r_data_wr),
    .mem_wr_en(r_mem_wr_en), .done(r_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    int ai, idx, mi, ki, ni;
    logic [7:0] v;
    v  = 8'd0;
    ai = int'(a);
    if (ai >= 'h4000 && ai < 'h4000 + M * K) begin
      idx = ai - 'h4000;
      mi  = idx / K;
      ki  = idx % K;
      case (pat)
        1: v = 8'd1;
        2: v = 8'hFF;
        default: v = 8'(mi + ki);
      endcase
    end else if (ai >= 'h2000 && ai < 'h2000 + K * N) begin
      idx = ai - 'h2000;
      ki  = idx / N;
      ni  = idx % N;
      case (pat)
        1: v = 8'd1;
        2: v = 8'h7F;
        default: v = 8'(ki - ni);
      endcase
    end
    return v;
  endfunction

  always @(posedge clk) begin
    data_rd   <= mem_rd(addr_rd);
    r_data_rd <= mem_rd(r_addr_rd);
  end

  function automatic int gold(input int mi, input int ni);
    int s;
    s = 0;
    for (int ki = 0; ki < K; ki++) s += (mi + ki) * (ki - ni);
    return s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_exp(input vec_t v);
    int g;
    logic [31:0] a;
    for (int mi = 0; mi < M; mi++) begin
      for (int ni = 0; ni < N; ni++) begin
        g = gold(mi, ni);
        a = 32'('h6000 + mi * N + ni);
        q.push_back('{a, v.use_model ? 32'(g) : v.exp_val});
        rq.push_back('{a, v.use_model ? ((g < 0) ? 32'd0 : 32'(g)) : v.exp_relu});
      end
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_addr_rd"}, addr_rd, 32'h4000);
    chk({tag, "_addr_wr"}, addr_wr, 32'h6000);
    chk({tag, "_data_wr"}, data_wr, 32'h0);
    chk({tag, "_wr_en"}, {31'd0, mem_wr_en}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_r_addr_rd"}, r_addr_rd, 32'h4000);
    chk({tag, "_r_done"}, {31'd0, r_done}, 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    q.delete();
    rq.delete();
  endtask

  task automatic start_run();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
  endtask

  task automatic monitor(input int max_cyc, input bit expect_done, input int drop_at);
    wr_t e;
    int  first_wr, nwr, rnwr, dc;
    bit  prev_wr, rprev_wr, done_seen, rdone_seen;
    first_wr = -1; nwr = 0; rnwr = 0; dc = 0;
    prev_wr = 0; rprev_wr = 0; done_seen = 0; rdone_seen = 0;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      if (c == drop_at) start = 1'b0;
      if (mem_wr_en) begin
        nwr++;
        if (first_wr < 0) begin
          first_wr = c;
          chk("first_wr_cycle", 32'(c), 32'(FIRST_WR));
        end
        chk("wr_pulse", {31'd0, prev_wr}, 32'd0);
        if (q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL sb_underflow: write to 0x%08h with no expected entry", addr_wr);
        end else begin
          e = q.pop_front();
          chk("wr_addr", addr_wr, e.addr);
          chk("wr_data", data_wr, e.data);
        end
      end
      if (r_mem_wr_en) begin
        rnwr++;
        chk("r_wr_pulse", {31'd0, rprev_wr}, 32'd0);
        if (rq.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL r_sb_underflow: write to 0x%08h with no expected entry", r_addr_wr);
        end else begin
          e = rq.pop_front();
          chk("r_wr_addr", r_addr_wr, e.addr);
          chk("r_wr_data", r_data_wr, e.data);
        end
      end
      prev_wr  = mem_wr_en;
      rprev_wr = r_mem_wr_en;
      if (done_seen) chk("done_sticky", {31'd0, done}, 32'd1);
      if (rdone_seen) chk("r_done_sticky", {31'd0, r_done}, 32'd1);
      if (done && !done_seen) begin
        done_seen = 1;
        dc = c;
        chk("done_cycle", 32'(c), 32'(DONE_CYC));
      end
      if (r_done && !rdone_seen) begin
        rdone_seen = 1;
        chk("r_done_cycle", 32'(c), 32'(DONE_CYC));
      end
      if (done_seen && c >= dc + 3) break;
    end
    if (expect_done) begin
      if (!done_seen) begin
        n_tests++; n_fail++;
        $display("FAIL done_timeout: done not seen within %0d cycles", max_cyc);
      end
      chk("wr_count", 32'(nwr), 32'(M * N));
      chk("r_wr_count", 32'(rnwr), 32'(M * N));
      chk("sb_left", 32'(q.size()), 32'd0);
      chk("r_sb_left", 32'(rq.size()), 32'd0);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{pat: 1, drop_at: -1, use_model: 1'b0, exp_val: 32'd9,         exp_relu: 32'd9};
    vecs[1] = '{pat: 2, drop_at: -1, use_model: 1'b0, exp_val: 32'hFFFFFB89, exp_relu: 32'd0};
    vecs[2] = '{pat: 3, drop_at: 1,  use_model: 1'b1, exp_val: 32'd0,         exp_relu: 32'd0};

    rst_n = 1'b0;
    start = 1'b0;
    do_reset();

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_addr_rd", addr_rd, 32'h4000);
      chk("idle_wr_en", {31'd0, mem_wr_en}, 32'd0);
      chk("idle_done", {31'd0, done}, 32'd0);
    end

    for (int i = 0; i < 3; i++) begin
      do_reset();
      pat = vecs[i].pat;
      push_exp(vecs[i]);
      start_run();
      monitor(DONE_CYC + 100, 1'b1, vecs[i].drop_at);
    end

    // Asynchronous reset in the middle of the 50th result, start held high throughout.
    do_reset();
    pat = 3;
    push_exp(vecs[2]);
    start_run();
    monitor(49 * FIRST_WR + 10, 1'b0, -1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    q.delete();
    rq.delete();
    push_exp(vecs[2]);
    @(negedge clk);
    chk_reset_vals("rst_held");
    rst_n = 1'b1;
    @(posedge clk);
    monitor(DONE_CYC + 100, 1'b1, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
